decode_lane_arbiter: RTL and testbench

- Two fetch lanes (hardware threads) share one set of format-specific decoders (B, D, DS, X, ...) in decode.
- Each lane pushes instructions into its own small FIFO. The arbiter picks one lane per cycle, round-robin, and drives a single registered instruction stream into the decoders.
- It honours the downstream stall and supports per-lane flush on redirect.

---
 rtl/decode_lane_arbiter.sv | 156 +++++++++++++++
 tb/tb_decode_lane_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_lane_arbiter.sv
// Two-lane fetch arbiter: per-lane FIFOs feeding one registered instruction stream
// into the shared format decoders, round-robin between lanes, with stall and per-lane flush.
module decode_lane_arbiter #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int fifoDepth               = 4,
   parameter int fifoPtrWidth            = 2
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 stall_i,
   input  logic [1:0]                           flush_i,
   input  logic [1:0]                           laneEnable_i,
   output logic [1:0]                           laneReady_o,
   input  logic [2*instructionWidth-1:0]        laneInstruction_i,
   input  logic [2*addressWidth-1:0]            laneAddress_i,
   input  logic [1:0]                           laneIs64Bit_i,
   input  logic [2*PidSize-1:0]                 lanePid_i,
   input  logic [2*TidSize-1:0]                 laneTid_i,
   input  logic [2*instructionCounterWidth-1:0] laneMajId_i,
   output logic                                 enable_o,
   output logic [instructionWidth-1:0]          instruction_o,
   output logic [5:0]                           instructionOpcode_o,
   output logic [addressWidth-1:0]              instructionAddress_o,
   output logic                                 is64Bit_o,
   output logic [PidSize-1:0]                   instructionPid_o,
   output logic [TidSize-1:0]                   instructionTid_o,
   output logic [instructionCounterWidth-1:0]   instructionMajId_o,
   output logic                                 grantLane_o,
   output logic [1:0]                           overflow_o
);

   typedef struct packed {
      logic [instructionWidth-1:0]        instruction;
      logic [addressWidth-1:0]            address;
      logic                               is64Bit;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [instructionCounterWidth-1:0] majId;
   } entryType;

   localparam logic [fifoPtrWidth:0] fullCount = (fifoPtrWidth + 1)'(fifoDepth);

   entryType                fifoMem [2][fifoDepth];
   entryType                laneEntry [2];
   logic [fifoPtrWidth:0]   count [2];
   logic [fifoPtrWidth-1:0] readPtr [2];
   logic [fifoPtrWidth-1:0] writePtr [2];
   logic [1:0]              laneReady;
   logic [1:0]              eligible;
   logic [1:0]              pushEnable;
   logic [1:0]              popEnable;
   logic                    grantValid;
   logic                    grantLane;
   logic                    priorityLane;
   logic                    enableReg;
   logic                    grantLaneReg;
   logic [1:0]              overflowReg;
   entryType                outEntry;

   // Lane 0 occupies the upper half of every packed lane bus.
   for (genvar n = 0; n < 2; n++) begin : gLaneUnpack
      assign laneEntry[n] = {laneInstruction_i[(1-n)*instructionWidth +: instructionWidth],
                             laneAddress_i[(1-n)*addressWidth +: addressWidth],
                             laneIs64Bit_i[1-n],
                             lanePid_i[(1-n)*PidSize +: PidSize],
                             laneTid_i[(1-n)*TidSize +: TidSize],
                             laneMajId_i[(1-n)*instructionCounterWidth +: instructionCounterWidth]};
   end

   always_comb begin
      for (int n = 0; n < 2; n++) begin
         laneReady[n]  = (count[n] != fullCount);
         pushEnable[n] = laneEnable_i[n] && laneReady[n] && !flush_i[n];
         eligible[n]   = (count[n] != '0) && !flush_i[n];
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grantValid = |eligible;
      grantLane  = (&eligible) ? priorityLane : eligible[1];
      popEnable  = 2'b00;
      if (!stall_i && grantValid) popEnable[grantLane] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int n = 0; n < 2; n++) begin
            count[n]    <= '0;
            readPtr[n]  <= '0;
            writePtr[n] <= '0;
         end
         overflowReg <= 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (laneEnable_i[n] && !laneReady[n]) overflowReg[n] <= 1'b1;
            if (flush_i[n]) begin
               count[n]    <= '0;
               readPtr[n]  <= '0;
               writePtr[n] <= '0;
            end else begin
               if (pushEnable[n]) writePtr[n] <= writePtr[n] + 1'b1;
               if (popEnable[n]) readPtr[n] <= readPtr[n] + 1'b1;
               if (pushEnable[n] && !popEnable[n]) count[n] <= count[n] + 1'b1;
               else if (popEnable[n] && !pushEnable[n]) count[n] <= count[n] - 1'b1;
            end
         end
      end
   end

   // NOTE: FIFO storage is not reset; the counts and pointers alone define validity.
   always_ff @(posedge clock_i) begin
      for (int n = 0; n < 2; n++) begin
         if (pushEnable[n]) fifoMem[n][writePtr[n]] <= laneEntry[n];
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         outEntry     <= '0;
         enableReg    <= 1'b0;
         grantLaneReg <= 1'b0;
         priorityLane <= 1'b0;
      end else if (!stall_i) begin
         if (grantValid) begin
            outEntry     <= fifoMem[grantLane][readPtr[grantLane]];
            enableReg    <= 1'b1;
            grantLaneReg <= grantLane;
            priorityLane <= ~grantLane;
         end else begin
            enableReg <= 1'b0;
         end
      end else if (flush_i[grantLaneReg]) begin
         // A flushed lane must not keep its instruction in front of the decoders while stalled.
         enableReg <= 1'b0;
      end
   end

   assign laneReady_o          = laneReady;
   assign overflow_o           = overflowReg;
   assign enable_o             = enableReg;
   assign grantLane_o          = grantLaneReg;
   assign instruction_o        = outEntry.instruction;
   assign instructionOpcode_o  = outEntry.instruction[instructionWidth-1 -: 6];
   assign instructionAddress_o = outEntry.address;
   assign is64Bit_o            = outEntry.is64Bit;
   assign instructionPid_o     = outEntry.pid;
   assign instructionTid_o     = outEntry.tid;
   assign instructionMajId_o   = outEntry.majId;

endmodule

// File: tb/tb_decode_lane_arbiter.sv
// Scoreboard bench for decode_lane_arbiter: expected instructions are queued in grant
// order as they are pushed and compared whenever the arbiter presents a new instruction.
module tb_decode_lane_arbiter;

   localparam int AW  = 64;
   localparam int IW  = 32;
   localparam int PW  = 20;
   localparam int TW  = 16;
   localparam int MW  = 64;
   localparam int FD  = 4;
   localparam int FPW = 2;

   typedef struct {
      logic          lane;
      logic [MW-1:0] majId;
      logic [AW-1:0] addr;
      logic [IW-1:0] instr;
      logic [PW-1:0] pid;
      logic [TW-1:0] tid;
      logic          is64;
   } expType;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [1:0]    flush;
   logic [1:0]    laneEn;
   logic [1:0]    laneReady;
   logic          enable;
   logic [IW-1:0] instr;
   logic [5:0]    opcode;
   logic [AW-1:0] addr;
   logic          is64;
   logic [PW-1:0] pid;
   logic [TW-1:0] tid;
   logic [MW-1:0] majId;
   logic          grantLane;
   logic [1:0]    overflow;

   expType laneDrive [2];
   expType expQ [$];
   int     checkCount = 0;
   int     errorCount = 0;

   always #5 clk = ~clk;

   decode_lane_arbiter #(
      .addressWidth(AW), .instructionWidth(IW), .PidSize(PW), .TidSize(TW),
      .instructionCounterWidth(MW), .fifoDepth(FD), .fifoPtrWidth(FPW)
   ) dut (
      .clock_i(clk),
      .reset_i(rst),
      .stall_i(stall),
      .flush_i(flush),
      .laneEnable_i(laneEn),
      .laneReady_o(laneReady),
      .laneInstruction_i({laneDrive[0].instr, laneDrive[1].instr}),
      .laneAddress_i({laneDrive[0].addr, laneDrive[1].addr}),
      .laneIs64Bit_i({laneDrive[0].is64, laneDrive[1].is64}),
      .lanePid_i({laneDrive[0].pid, laneDrive[1].pid}),
      .laneTid_i({laneDrive[0].tid, laneDrive[1].tid}),
      .laneMajId_i({laneDrive[0].majId, laneDrive[1].majId}),
      .enable_o(enable),
      .instruction_o(instr),
      .instructionOpcode_o(opcode),
      .instructionAddress_o(addr),
      .is64Bit_o(is64),
      .instructionPid_o(pid),
      .instructionTid_o(tid),
      .instructionMajId_o(majId),
      .grantLane_o(grantLane),
      .overflow_o(overflow)
   );

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("FAIL %s got=%0h want=%0h", tag, actual, expected);
      end
   endtask

   function automatic expType makeEntry(input logic lane, input int unsigned id);
      expType e;
      e.lane  = lane;
      e.majId = MW'(id);
      e.addr  = 64'h1000 + (lane ? 64'h8000 : 64'h0) + 64'(id) * 4;
      e.instr = 32'h7C00_0000 ^ (32'(id) << 8) ^ 32'(lane);
      e.pid   = 20'h100 + 20'(lane);
      e.tid   = 16'h20 + 16'(lane) + 16'(id);
      e.is64  = lane ^ id[0];
      return e;
   endfunction

   task automatic push(input expType e, input bit expectOut);
      laneDrive[e.lane] = e;
      laneEn[e.lane]    = 1'b1;
      if (expectOut) expQ.push_back(e);
   endtask

   // Advance through one rising edge; one-cycle strobes drop afterwards.
   task automatic step();
      @(negedge clk);
      laneEn = 2'b00;
      flush  = 2'b00;
   endtask

   task automatic doReset();
      rst    = 1'b1;
      stall  = 1'b0;
      flush  = 2'b00;
      laneEn = 2'b00;
      repeat (2) @(negedge clk);
      expQ.delete();
      rst = 1'b0;
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(expQ.size()), 64'd0);
      expQ.delete();
   endtask

   // A new instruction is presented after every unstalled edge that leaves enable_o high.
   always @(posedge clk) begin
      logic   stallAtEdge;
      logic   resetAtEdge;
      expType e;
      stallAtEdge = stall;
      resetAtEdge = rst;
      #1;
      if (!resetAtEdge && !stallAtEdge && enable === 1'b1) begin
         if (expQ.size() == 0) begin
            check("spuriousOutput", 64'(majId), 64'hDEAD);
         end else begin
            e = expQ.pop_front();
            check("outLane", 64'(grantLane), 64'(e.lane));
            check("outMajId", majId, e.majId);
            check("outAddr", addr, e.addr);
            check("outInstr", 64'(instr), 64'(e.instr));
            check("outOpcode", 64'(opcode), 64'(e.instr[31:26]));
            check("outPid", 64'(pid), 64'(e.pid));
            check("outTid", 64'(tid), 64'(e.tid));
            check("outIs64", 64'(is64), 64'(e.is64));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      expType e;
      laneDrive[0] = makeEntry(1'b0, 0);
      laneDrive[1] = makeEntry(1'b1, 0);
      doReset();
      check("resetEnable", 64'(enable), 64'd0);
      check("resetReady", 64'(laneReady), 64'd3);
      check("resetOverflow", 64'(overflow), 64'd0);
      check("resetMajId", majId, 64'd0);

      // Round-robin: both lanes loaded under stall, then strict alternation from lane 0.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(makeEntry(1'b0, i), 1'b1);
         push(makeEntry(1'b1, 10 + i), 1'b1);
         step();
      end
      stall = 1'b0;
      waitDrain("rrDrain", 20);
      step();
      check("rrIdleEnable", 64'(enable), 64'd0);

      // Full and overflow on lane 0.
      doReset();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(makeEntry(1'b0, i), i < 4);
         step();
         if (i == 2) check("fullReady3", 64'(laneReady[0]), 64'd1);
         if (i == 3) begin
            check("fullReady4", 64'(laneReady[0]), 64'd0);
            check("fullNoOverflowYet", 64'(overflow), 64'd0);
         end
         if (i == 4) check("overflowSet", 64'(overflow), 64'd1);
      end
      stall = 1'b0;
      waitDrain("fullDrain", 20);
      step();
      check("fullIdleEnable", 64'(enable), 64'd0);
      check("overflowSticky", 64'(overflow), 64'd1);
      check("fullReadyAfter", 64'(laneReady), 64'd3);

      // Latency and stall hold.
      doReset();
      e = makeEntry(1'b0, 20);
      e.addr = 64'h40;
      push(e, 1'b1);
      step();
      check("latencyNotYet", 64'(enable), 64'd0);
      push(makeEntry(1'b0, 21), 1'b1);
      step();
      check("latencyEnable", 64'(enable), 64'd1);
      check("latencyAddr", addr, 64'h40);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("holdEnable", 64'(enable), 64'd1);
         check("holdAddr", addr, 64'h40);
         check("holdMajId", majId, 64'd20);
      end
      stall = 1'b0;
      step();
      check("releaseMajId", majId, 64'd21);
      waitDrain("stallDrain", 10);
      step();
      check("stallIdleEnable", 64'(enable), 64'd0);

      // Flush of lane 1 while it is being presented under stall.
      doReset();
      stall = 1'b1;
      push(makeEntry(1'b0, 40), 1'b1);
      push(makeEntry(1'b1, 30), 1'b1);
      step();
      push(makeEntry(1'b0, 41), 1'b1);
      push(makeEntry(1'b1, 31), 1'b0);
      step();
      push(makeEntry(1'b1, 32), 1'b0);
      step();
      push(makeEntry(1'b1, 33), 1'b0);
      step();
      stall = 1'b0;
      step();
      step();
      stall = 1'b1;
      check("flushShowsLane1", 64'(grantLane), 64'd1);
      check("flushShowsMajId", majId, 64'd30);
      push(makeEntry(1'b1, 34), 1'b0);
      step();
      check("flushLane1Full", 64'(laneReady), 64'd1);
      check("flushHeldEnable", 64'(enable), 64'd1);
      flush = 2'b10;
      step();
      check("flushEnableDrop", 64'(enable), 64'd0);
      check("flushReady", 64'(laneReady), 64'd3);
      check("flushNoOverflow", 64'(overflow), 64'd0);
      stall = 1'b0;
      push(makeEntry(1'b1, 50), 1'b1);
      step();
      waitDrain("flushDrain", 10);
      step();
      check("flushIdleEnable", 64'(enable), 64'd0);

      // Opcode and sideband passthrough on lane 1.
      doReset();
      e = makeEntry(1'b1, 7);
      e.instr = 32'h4180_0010;
      e.pid   = 20'hABCDE;
      e.tid   = 16'h1234;
      e.is64  = 1'b1;
      push(e, 1'b1);
      step();
      step();
      check("opcodeValue", 64'(opcode), 64'd16);
      check("opcodeInstr", 64'(instr), 64'h4180_0010);
      check("opcodePid", 64'(pid), 64'hABCDE);
      check("opcodeTid", 64'(tid), 64'h1234);
      check("opcodeIs64", 64'(is64), 64'd1);
      waitDrain("opcodeDrain", 5);

      // Asynchronous reset mid-stream.
      doReset();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(makeEntry(1'b0, 60 + i), 1'b1);
         step();
      end
      stall = 1'b0;
      step();
      stall = 1'b1;
      check("midEnable", 64'(enable), 64'd1);
      check("midMajId", majId, 64'd60);
      #2 rst = 1'b1;
      #1;
      check("asyncEnable", 64'(enable), 64'd0);
      check("asyncMajId", majId, 64'd0);
      check("asyncInstr", 64'(instr), 64'd0);
      check("asyncAddr", addr, 64'd0);
      check("asyncGrant", 64'(grantLane), 64'd0);
      check("asyncReady", 64'(laneReady), 64'd3);
      expQ.delete();
      @(negedge clk);
      rst   = 1'b0;
      stall = 1'b0;
      e = makeEntry(1'b0, 5);
      push(e, 1'b1);
      step();
      check("postResetEdge1", 64'(enable), 64'd0);
      step();
      check("postResetEdge2", 64'(enable), 64'd1);
      check("postResetMajId", majId, 64'd5);
      waitDrain("postResetDrain", 5);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
